// File: rtl/vram_scanout_if.sv
// Bundle between the scanout engine and its surroundings: VRAM read port,
// frame base address and the DAC/sync pins.
//
// There is no valid/ready handshake on this bundle. The scanout block owns the
// VRAM read port every cycle. vram_data must carry the byte addressed by
// vram_addr one clock after that address was presented. base_addr is
// level-sampled once per frame.
`timescale 1ns/1ps
interface vram_scanout_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_data;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic                  pixel;
  logic                  frame_start;

  // Scanout engine side
  modport master (
    input  base_addr,
    input  vram_data,
    output vram_addr,
    output hsync,
    output vsync,
    output de,
    output pixel,
    output frame_start
  );

  // VRAM / display side
  modport slave (
    output base_addr,
    output vram_data,
    input  vram_addr,
    input  hsync,
    input  vsync,
    input  de,
    input  pixel,
    input  frame_start
  );
endinterface

// File: rtl/vram_scanout.sv
// VGA raster generator and 1bpp bitmap fetcher. Each bitmap byte covers
// 16 clocks (8 pixels doubled), and each bitmap row covers 2 lines.
// Three-stage pipeline:
//   stage 1: register the VRAM address and the counter-derived controls
//   stage 2: VRAM returns the byte; the controls are delayed to match
//   stage 3: select the bit; register the pixel and the sync/enable outputs
// All outputs therefore lag the raster counters by exactly 3 clocks.
`timescale 1ns/1ps
module vram_scanout #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int STRIDE     = 40,
  parameter int ADDR_WIDTH = 14
) (
  input  logic           i_clk,
  input  logic           i_rst,
  vram_scanout_if.master io_vram
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Raster counters and the per-frame base
  logic [H_W-1:0]        r_h_cnt;
  logic [V_W-1:0]        r_v_cnt;
  logic [ADDR_WIDTH-1:0] r_base_q;

  // Stage 1
  logic [ADDR_WIDTH-1:0] r_vram_addr;
  logic                  r_de_s1;
  logic                  r_hs_s1;
  logic                  r_vs_s1;
  logic                  r_fs_s1;
  logic [2:0]            r_hsub_s1;

  // Stage 2
  logic                  r_de_s2;
  logic                  r_hs_s2;
  logic                  r_vs_s2;
  logic                  r_fs_s2;
  logic [2:0]            r_hsub_s2;

  // Stage 3 (output registers)
  logic                  r_de;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_fs;
  logic                  r_pixel;

  // Counter-domain decode
  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_frame_top;
  logic                  w_de_c;
  logic                  w_hs_c;
  logic                  w_vs_c;
  logic [ADDR_WIDTH-1:0] w_base_eff;
  logic [31:0]           w_row_off;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [2:0]            w_bit_sel;

  assign w_h_last    = (r_h_cnt == H_W'(H_TOTAL - 1));
  assign w_v_last    = (r_v_cnt == V_W'(V_TOTAL - 1));
  assign w_frame_top = (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_de_c = (int'(r_h_cnt) < H_VISIBLE) && (int'(r_v_cnt) < V_VISIBLE);
  // Sync windows are active-low at the pins, so these are 0 inside the window.
  assign w_hs_c = !((int'(r_h_cnt) >= HS_START) && (int'(r_h_cnt) < HS_END));
  assign w_vs_c = !((int'(r_v_cnt) >= VS_START) && (int'(r_v_cnt) < VS_END));

  // The first fetch of a frame must already use the base being latched on
  // that same cycle, so bypass base_q at the top-left counter position.
  assign w_base_eff  = w_frame_top ? io_vram.base_addr : r_base_q;
  assign w_row_off   = 32'(r_v_cnt >> 1) * 32'(STRIDE);
  // Natural ADDR_WIDTH-bit wraparound gives the modulo-2^14 address.
  assign w_addr_next = w_base_eff + w_row_off[ADDR_WIDTH-1:0]
                     + ADDR_WIDTH'(r_h_cnt >> 4);

  // MSB is the leftmost pixel of each byte.
  assign w_bit_sel = 3'd7 - r_hsub_s2;

  // Horizontal / vertical raster counters, wrapping at the frame end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_W'(1);
    end
  end

  // Latch the bitmap base once per frame so buffer flips never tear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base_q <= '0;
    end else if (w_frame_top) begin
      r_base_q <= io_vram.base_addr;
    end
  end

  // Stage 1: present the VRAM address and capture the counter-derived controls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vram_addr <= '0;
      r_de_s1     <= 1'b0;
      r_hs_s1     <= 1'b1;
      r_vs_s1     <= 1'b1;
      r_fs_s1     <= 1'b0;
      r_hsub_s1   <= '0;
    end else begin
      r_vram_addr <= w_addr_next;
      r_de_s1     <= w_de_c;
      r_hs_s1     <= w_hs_c;
      r_vs_s1     <= w_vs_c;
      r_fs_s1     <= w_frame_top;
      r_hsub_s1   <= r_h_cnt[3:1];
    end
  end

  // Stage 2: delay the controls while VRAM produces the addressed byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_de_s2   <= 1'b0;
      r_hs_s2   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_fs_s2   <= 1'b0;
      r_hsub_s2 <= '0;
    end else begin
      r_de_s2   <= r_de_s1;
      r_hs_s2   <= r_hs_s1;
      r_vs_s2   <= r_vs_s1;
      r_fs_s2   <= r_fs_s1;
      r_hsub_s2 <= r_hsub_s1;
    end
  end

  // Stage 3: select the pixel bit (blanked outside DE) and register the pins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_de    <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_fs    <= 1'b0;
      r_pixel <= 1'b0;
    end else begin
      r_de    <= r_de_s2;
      r_hsync <= r_hs_s2;
      r_vsync <= r_vs_s2;
      r_fs    <= r_fs_s2;
      r_pixel <= r_de_s2 ? io_vram.vram_data[w_bit_sel] : 1'b0;
    end
  end

  assign io_vram.vram_addr   = r_vram_addr;
  assign io_vram.de          = r_de;
  assign io_vram.hsync       = r_hsync;
  assign io_vram.vsync       = r_vsync;
  assign io_vram.frame_start = r_fs;
  assign io_vram.pixel       = r_pixel;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout. Horizontal timing is the real 640x480 line; the
// vertical extent is shortened (8 visible lines, 15 per frame) so that several
// whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vram_scanout;

  localparam int H_VIS      = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_VIS      = 8;
  localparam int V_TOTAL    = 15;
  localparam int STRIDE     = 40;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_scanout_if #(.ADDR_WIDTH(14)) bus ();

  vram_scanout #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .STRIDE(40), .ADDR_WIDTH(14)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_vram(bus.master)
  );

  // Synchronous VRAM model, one clock of read latency
  logic [7:0] mem [0:16383];
  logic [7:0] vram_q = 8'h00;
  always @(posedge clk) vram_q <= mem[bus.vram_addr];
  assign bus.vram_data = vram_q;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0]  exp_q[$];           // {de, pixel} per output cycle
  logic [13:0] addr_log[int];      // VRAM_ADDR keyed by counter index
  int pix_ones;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit (got no finish, want finish)");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [13:0] exp_addr(input int n, input logic [13:0] b);
    int h, v;
    logic [31:0] s;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    s = 32'(b) + 32'((v >> 1) * STRIDE) + 32'(h >> 4);
    return s[13:0];
  endfunction

  function automatic logic [1:0] exp_out(input int n, input logic [13:0] b);
    int h, v;
    logic de;
    logic [7:0] byt;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    de = (h < H_VIS) && (v < V_VIS);
    byt = mem[exp_addr(n, b)];
    return {de, de ? byt[7 - ((h >> 1) & 7)] : 1'b0};
  endfunction

  function automatic logic is_vis(input int n);
    return ((n % H_TOTAL) < H_VIS) && (((n / H_TOTAL) % V_TOTAL) < V_VIS);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [13:0] b);
    bus.base_addr = b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Runs n_edges clocks after a reset release. Expected {de,pixel} for the
  // counter state present at each edge is queued, then popped 3 clocks later
  // when the DUT shows it. BASE_ADDR switches to new_base right after
  // change_edge (never, if change_edge < 0).
  task automatic run_scoreboard(input int n_edges, input logic [13:0] first_base,
                                input int change_edge, input logic [13:0] new_base);
    logic [1:0]  e;
    logic [1:0]  got;
    logic [13:0] b;
    int n, f;
    exp_q.delete();
    addr_log.delete();
    pix_ones = 0;
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk);
      #1;
      n = k - 1;
      f = n / FRAME_CLKS;
      b = (f > 0 && change_edge >= 0 && change_edge < f * FRAME_CLKS + 1) ? new_base : first_base;
      exp_q.push_back(exp_out(n, b));
      if (k == change_edge) bus.base_addr = new_base;
      @(negedge clk);
      addr_log[n] = bus.vram_addr;
      if (is_vis(n)) begin
        n_checks++;
        if (bus.vram_addr !== exp_addr(n, b))
          $display("FAIL vram_addr idx=%0d got=%h want=%h", n, bus.vram_addr, exp_addr(n, b));
        else n_pass++;
      end
      if (k >= 3) begin
        e = exp_q.pop_front();
        got = {bus.de, bus.pixel};
        if (bus.pixel === 1'b1) pix_ones++;
        n_checks++;
        if (got !== e)
          $display("FAIL de_pixel idx=%0d got=%b want=%b", k - 3, got, e);
        else n_pass++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int fs_cnt;
    logic fs_at3;
    fill_random();
    do_reset(14'h0000);
    repeat (100) @(negedge clk);
    n_checks++;
    if (bus.de !== 1'b1) $display("FAIL reset_pre_de got=%b want=1", bus.de);
    else n_pass++;
    // Assert reset away from any clock edge; outputs must clear immediately.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.hsync !== 1'b1) $display("FAIL reset_hsync got=%b want=1", bus.hsync); else n_pass++;
    n_checks++;
    if (bus.vsync !== 1'b1) $display("FAIL reset_vsync got=%b want=1", bus.vsync); else n_pass++;
    n_checks++;
    if (bus.de !== 1'b0) $display("FAIL reset_de got=%b want=0", bus.de); else n_pass++;
    n_checks++;
    if (bus.pixel !== 1'b0) $display("FAIL reset_pixel got=%b want=0", bus.pixel); else n_pass++;
    n_checks++;
    if (bus.vram_addr !== 14'h0) $display("FAIL reset_addr got=%h want=0", bus.vram_addr); else n_pass++;
    n_checks++;
    if (bus.frame_start !== 1'b0) $display("FAIL reset_fs got=%b want=0", bus.frame_start); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    fs_cnt = 0;
    fs_at3 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (k == 3) fs_at3 = bus.frame_start;
    end
    n_checks++;
    if (fs_at3 !== 1'b1) $display("FAIL reset_fs_clock3 got=%b want=1", fs_at3); else n_pass++;
    n_checks++;
    if (fs_cnt != 1) $display("FAIL reset_fs_count got=%0d want=1", fs_cnt); else n_pass++;
  endtask

  task automatic test_line_timing();
    logic pde, phs;
    int de_rise, de_fall, hs_f1, hs_f2, hs_r;
    do_reset(14'h0000);
    pde = 1'b0; phs = 1'b1;
    de_rise = -1; de_fall = -1; hs_f1 = -1; hs_f2 = -1; hs_r = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (bus.de && !pde && de_rise < 0) de_rise = k;
      if (!bus.de && pde && de_fall < 0) de_fall = k;
      if (!bus.hsync && phs) begin
        if (hs_f1 < 0) hs_f1 = k;
        else if (hs_f2 < 0) hs_f2 = k;
      end
      if (bus.hsync && !phs && hs_r < 0) hs_r = k;
      pde = bus.de;
      phs = bus.hsync;
    end
    n_checks++;
    if (de_rise != 3) $display("FAIL line_de_latency got=%0d want=3", de_rise); else n_pass++;
    n_checks++;
    if (de_fall - de_rise != 640) $display("FAIL line_de_width got=%0d want=640", de_fall - de_rise); else n_pass++;
    n_checks++;
    if (hs_f1 - de_rise != 656) $display("FAIL line_hs_after_de got=%0d want=656", hs_f1 - de_rise); else n_pass++;
    n_checks++;
    if (hs_r - hs_f1 != 96) $display("FAIL line_hs_width got=%0d want=96", hs_r - hs_f1); else n_pass++;
    n_checks++;
    if (hs_f2 - hs_f1 != 800) $display("FAIL line_hs_period got=%0d want=800", hs_f2 - hs_f1); else n_pass++;
  endtask

  task automatic test_frame_timing();
    logic pvs, phs;
    int fs1, fs2, fs_cnt, vs_f, vs_r, hs_falls, de_cnt;
    do_reset(14'h0000);
    pvs = 1'b1; phs = 1'b1;
    fs1 = -1; fs2 = -1; fs_cnt = 0; vs_f = -1; vs_r = -1; hs_falls = 0; de_cnt = 0;
    for (int k = 1; k <= 2 * FRAME_CLKS + 100; k++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (fs1 > 0 && fs2 < 0) begin
        if (bus.de === 1'b1) de_cnt++;
        if (!bus.hsync && phs) hs_falls++;
      end
      if (!bus.vsync && pvs && vs_f < 0) vs_f = k;
      if (bus.vsync && !pvs && vs_r < 0) vs_r = k;
      pvs = bus.vsync;
      phs = bus.hsync;
    end
    n_checks++;
    if (fs2 - fs1 != FRAME_CLKS) $display("FAIL frame_fs_period got=%0d want=%0d", fs2 - fs1, FRAME_CLKS); else n_pass++;
    n_checks++;
    if (fs_cnt != 3) $display("FAIL frame_fs_pulses got=%0d want=3", fs_cnt); else n_pass++;
    n_checks++;
    if (hs_falls != V_TOTAL) $display("FAIL frame_lines got=%0d want=%0d", hs_falls, V_TOTAL); else n_pass++;
    n_checks++;
    if (vs_f - fs1 != 10 * H_TOTAL) $display("FAIL frame_vs_start got=%0d want=%0d", vs_f - fs1, 10 * H_TOTAL); else n_pass++;
    n_checks++;
    if (vs_r - vs_f != 2 * H_TOTAL) $display("FAIL frame_vs_width got=%0d want=%0d", vs_r - vs_f, 2 * H_TOTAL); else n_pass++;
    n_checks++;
    if (de_cnt != V_VIS * H_VIS) $display("FAIL frame_de_count got=%0d want=%0d", de_cnt, V_VIS * H_VIS); else n_pass++;
  endtask

  task automatic test_datapath();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[0] = 8'h80;
    do_reset(14'h0000);
    run_scoreboard(2 * H_TOTAL + 20, 14'h0000, -1, 14'h0000);
    n_checks++;
    if (addr_log[2 * H_TOTAL + 16] !== 14'd41)
      $display("FAIL data_addr_h16_v2 got=%0d want=41", addr_log[2 * H_TOTAL + 16]);
    else n_pass++;
    n_checks++;
    if (pix_ones != 4) $display("FAIL data_ones got=%0d want=4", pix_ones); else n_pass++;
  endtask

  task automatic test_pattern();
    fill_random();
    do_reset(14'h0123);
    run_scoreboard(V_VIS * H_TOTAL + 10, 14'h0123, -1, 14'h0123);
  endtask

  task automatic test_base_latch();
    fill_random();
    do_reset(14'h0000);
    run_scoreboard(FRAME_CLKS + 400, 14'h0000, 2000, 14'h1000);
    n_checks++;
    if (addr_log[3 * H_TOTAL + 32] !== 14'd42)
      $display("FAIL base_midframe got=%h want=%h", addr_log[3 * H_TOTAL + 32], 14'd42);
    else n_pass++;
    n_checks++;
    if (addr_log[FRAME_CLKS] !== 14'h1000)
      $display("FAIL base_next_first got=%h want=1000", addr_log[FRAME_CLKS]);
    else n_pass++;
    n_checks++;
    if (addr_log[FRAME_CLKS + 16] !== 14'h1001)
      $display("FAIL base_next_byte1 got=%h want=1001", addr_log[FRAME_CLKS + 16]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    fill_random();
    do_reset(14'h3FF0);
    run_scoreboard(H_TOTAL + 10, 14'h3FF0, -1, 14'h3FF0);
    n_checks++;
    if (addr_log[15 * 16] !== 14'h3FFF)
      $display("FAIL wrap_byte15 got=%h want=3fff", addr_log[15 * 16]);
    else n_pass++;
    n_checks++;
    if (addr_log[16 * 16] !== 14'h0000)
      $display("FAIL wrap_byte16 got=%h want=0000", addr_log[16 * 16]);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.base_addr = 14'h0000;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_datapath();
    test_pattern();
    test_base_latch();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
